// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative multiplier: mode encodings, FSM state codes
// and the data-bus width helpers used to size the double-width product.
package mul_iter_pkg;

    localparam int DATA_BUS_W = 32;

    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SS = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int double_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Start/done handshake bundle between the EX stage (master) and mul_iter (slave).
// Handshake: mul_en is sampled only while idle; done pulses one cycle with result_mul valid.
interface mul_iter_if
    import mul_iter_pkg::*;
#(
    parameter int WIDTH = DATA_BUS_W
);
    logic                         mul_en;
    logic [1:0]                   mode;
    logic                         kill;
    logic [WIDTH-1:0]             op1;
    logic [WIDTH-1:0]             op2;
    logic                         busy;
    logic                         done;
    logic [double_w(WIDTH)-1:0]   result_mul;
    logic [1:0]                   dbg_state;

    modport master (
        output mul_en, mode, kill, op1, op2,
        input  busy, done, result_mul, dbg_state
    );

    modport slave (
        input  mul_en, mode, kill, op1, op2,
        output busy, done, result_mul, dbg_state
    );
endinterface

// File: rtl/mul_iter_abs.sv
// Conditional two's-complement negate; yields the unsigned magnitude when i_neg marks
// a negative operand, and re-applies the sign to the final product.
module mul_iter_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// then a sign fixup, with a zero-operand fast path and kill flush.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int WIDTH = DATA_BUS_W,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_iter_if.slave bus
);
    localparam int DW = double_w(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_prod;
    logic [DW-1:0]    r_result;

    logic             w_signed1;
    logic             w_signed2;
    logic             w_neg1;
    logic             w_neg2;
    logic             w_zero;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [DW-1:0]    w_fix;

    // Reserved mode 11 falls through as unsigned x unsigned.
    assign w_signed1 = (bus.mode == MUL_SS) || (bus.mode == MUL_SU);
    assign w_signed2 = (bus.mode == MUL_SS);
    assign w_neg1    = w_signed1 & bus.op1[WIDTH-1];
    assign w_neg2    = w_signed2 & bus.op2[WIDTH-1];
    assign w_zero    = (bus.op1 == '0) || (bus.op2 == '0);

    mul_iter_abs #(.WIDTH(WIDTH)) u_abs_op1 (.i_val(bus.op1), .i_neg(w_neg1), .o_val(w_mag1));
    mul_iter_abs #(.WIDTH(WIDTH)) u_abs_op2 (.i_val(bus.op2), .i_neg(w_neg2), .o_val(w_mag2));
    mul_iter_abs #(.WIDTH(DW))    u_abs_fix (.i_val({r_acc, r_mplier}), .i_neg(r_neg), .o_val(w_fix));

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (bus.kill) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mul_en) begin
                        r_mcand  <= w_mag1;
                        r_mplier <= w_mag2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_neg1 ^ w_neg2;
                        if (w_zero) begin
                            r_prod  <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    // Carry lands in the accumulator MSB as {carry, acc, mplier} shifts right.
                    r_acc    <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_prod  <= w_fix;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_result <= r_prod;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // The new product is only published once the DONE cycle survives a kill.
    assign bus.result_mul = ((r_state == ST_DONE) && !bus.kill) ? r_prod : r_result;
    assign bus.done       = (r_state == ST_DONE) && !bus.kill;
    assign bus.busy       = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.dbg_state  = r_state;

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative, parametrised shift-add integer multiplier for the EX stage. It replaces the single-cycle array multiplier with a multi-cycle unit.
- Supports signed×signed, signed×unsigned and unsigned×unsigned modes, and produces the full 2×WIDTH product.
- Uses a start/done handshake with a kill input, so the pipeline can stall on it and flush it.

Parameters:
- WIDTH, 32, operand width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- mul_en  input  1  start request; sampled only in IDLE.
- mode  input  2  00 unsigned×unsigned, 01 signed×signed, 10 signed(op1)×unsigned(op2), 11 reserved (treated as 00).
- kill  input  1  flush; aborts any operation in flight.
- op1  input  WIDTH  multiplicand.
- op2  input  WIDTH  multiplier.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result_mul is valid.
- result_mul  output  2*WIDTH  product; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state: FSM=IDLE; busy=0; done=0; result_mul=0; internal accumulator and counter = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - mul_en=1 and kill=0 → capture the magnitudes |op1| and |op2| according to mode.
  - Capture neg = sign(op1 as interpreted) XOR sign(op2 as interpreted).
  - Clear the accumulator, set count=0 and go to CALC.
  - busy rises on the following cycle.
- Fast path: at capture, if either operand is 0, skip CALC and go straight to DONE with result 0.
- CALC, per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator's upper WIDTH bits, with a WIDTH+1-bit carry.
  - Shift {carry, acc, multiplier} right by 1.
  - count++.
  - After WIDTH iterations, go to FIX.
- FIX: if neg=1, result_mul = two's complement of the 2×WIDTH magnitude; otherwise the magnitude is passed through. Go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency, from the cycle mul_en is sampled to the done cycle:
  - Normal path: WIDTH+2 cycles (34 for WIDTH=32).
  - Fast path: 1 cycle.
- Throughput: a new mul_en may be sampled in the cycle after done (IDLE). mul_en while busy is ignored; no queueing.
- Magnitude of the most negative value: taking the magnitude of -2^(WIDTH-1) yields 2^(WIDTH-1) as an unsigned value. The magnitude path must be WIDTH-bit unsigned, so the product of two most-negative values is exact: 2^(2*WIDTH-2).
- Unsigned mode: operand MSBs are not sign bits. neg=0 always.
- kill:
  - In any state, kill=1 forces IDLE on the next edge, with busy=0.
  - done is not asserted for the killed operation, including a kill in the DONE cycle.
  - result_mul keeps its previous value.
- kill with mul_en in IDLE: kill wins, and the request is dropped.
- Reset mid-operation: all state clears immediately (asynchronously); no done pulse.
- Inputs are sampled only at the start. Changes to op1, op2 or mode during CALC have no effect.

Decomposition:
- Shared package/include, alongside the existing bus and funct headers, holds:
  - mode encodings MUL_UU, MUL_SS, MUL_SU;
  - FSM state localparams;
  - DOUBLE_DATA_BUS width macros.
- One natural sub-module, mul_iter_abs: a combinational conditional two's-complement negate (WIDTH-parametrised). It is instantiated for op1, op2 and the 2×WIDTH final fixup (parameter override).
- Datapath and FSM stay in mul_iter.

Test Plan:
- WIDTH=32, mode=01, op1=7, op2=-3 (0xFFFFFFFD) → done after 34 cycles; result_mul=0xFFFFFFFF_FFFFFFEB (-21).
- mode=00, op1=0xFFFFFFFF, op2=0xFFFFFFFF → result_mul=0xFFFFFFFE_00000001. mode=01 with the same operands → 0x00000000_00000001.
- mode=01, op1=op2=0x80000000 → result_mul=0x40000000_00000000. mode=10, op1=0x80000000, op2=2 → 0xFFFFFFFF_00000000.
- op1=0, op2=12345, mode=01 → done on the next cycle; result 0. Immediately after, start 5×6 → result 30 after 34 cycles.
- Start 9×9, then assert kill at cycle 10 → busy drops; no done; result_mul unchanged. Then start 2×3 → result 6. Separately, assert mul_en during busy → ignored.
- Assert rst_n=0 mid-CALC (cycle 15) → busy=0, done=0, result_mul=0 immediately, before the next clock edge. Repeat the random signed/unsigned regression with WIDTH=8 and WIDTH=32 against a reference model.
